// File: rtl/byte_word_assembler_128_pkg.sv
// Shared constants for the byte-to-word assembler and the downstream shift-register stage.
// Holds the default widths, the derived beat count and the beat-counter width.
package byte_word_assembler_128_pkg;

   localparam int DATA_W_DEF = 128;
   localparam int IN_W_DEF   = 8;
   localparam int BEATS      = DATA_W_DEF / IN_W_DEF;
   localparam int CNT_W      = $clog2(BEATS);

endpackage : byte_word_assembler_128_pkg

// File: rtl/byte_word_assembler_128_beat_counter.sv
// Modulo-N beat counter with enable.
// Flags the last beat of a word so the top can close the assembly.
module byte_word_assembler_128_beat_counter #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         last_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign last_o = (cnt_q == W'(N - 1));
   assign cnt_o  = cnt_q;

   // Next count: advance on enable, wrap after the last beat.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = last_o ? {W{1'b0}} : (cnt_q + W'(1));
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : byte_word_assembler_128_beat_counter

// File: rtl/byte_word_assembler_128.sv
// Packs a byte stream MSB-first into 128-bit words behind a double buffer
// (assembly register + output register) so one byte per cycle is sustained.
module byte_word_assembler_128
   import byte_word_assembler_128_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IN_W   = IN_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        beat_cnt
);

   localparam int BEATS_L = DATA_W / IN_W;

   logic [DATA_W-1:0] asm_q;
   logic [DATA_W-1:0] asm_d;
   logic [DATA_W-1:0] out_data_q;
   logic [DATA_W-1:0] out_data_d;
   logic              out_valid_q;
   logic              out_valid_d;
   logic              asm_full_q;
   logic              asm_full_d;
   logic [DATA_W-1:0] word_s;
   logic [CNT_W-1:0]  cnt_s;
   logic              last_s;
   logic              accept_s;
   logic              can_load_s;

   assign in_ready   = !asm_full_q;
   assign accept_s   = in_valid && !asm_full_q;
   assign can_load_s = !out_valid_q || out_ready;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign beat_cnt   = cnt_s;

   byte_word_assembler_128_beat_counter #(
      .N (BEATS_L),
      .W (CNT_W)
   ) u_beat_counter (
      .clock  (clock),
      .reset  (reset),
      .en_i   (accept_s),
      .cnt_o  (cnt_s),
      .last_o (last_s)
   );

   // Assembly word with the incoming byte merged into its slot; on the final beat this is the complete word.
   always_comb begin
      word_s = asm_q;
      for (int k = 0; k < BEATS_L; k++) begin
         word_s[DATA_W-1-k*IN_W -: IN_W] = (accept_s && (cnt_s == CNT_W'(k))) ?
                                          in_data : asm_q[DATA_W-1-k*IN_W -: IN_W];
      end
      asm_d = word_s;
   end

   // Output buffer control: drain a held word first, else load a freshly completed word, else retire.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      asm_full_d  = asm_full_q;
      if (asm_full_q) begin
         if (can_load_s) begin
            out_data_d  = asm_q;
            out_valid_d = 1'b1;
            asm_full_d  = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
      end else if (accept_s && last_s) begin
         if (can_load_s) begin
            out_data_d  = word_s;
            out_valid_d = 1'b1;
         end else begin
            asm_full_d  = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Assembly and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         asm_q       <= {DATA_W{1'b0}};
         out_data_q  <= {DATA_W{1'b0}};
         out_valid_q <= 1'b0;
         asm_full_q  <= 1'b0;
      end else begin
         asm_q       <= asm_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         asm_full_q  <= asm_full_d;
      end
   end

endmodule : byte_word_assembler_128
